// File: rtl/interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// interrupt_arbiter
//
// Purpose:
//   Merges four level-sensitive peripheral interrupt requests into one CPU
//   interrupt line. When idle, the lowest-numbered enabled pending source is
//   selected. The block then raises the CPU interrupt and waits for the CPU
//   acknowledge. It pulses the acknowledge back to the selected peripheral and
//   waits a bounded time for that peripheral to drop its request. A source
//   that does not drop in time is recorded in the OVERRUN register.
//   The block has a 4-byte register window on a shared IO bus:
//     +0 MASK     RW  bits 3:0, 1 = source enabled
//     +1 STATUS   RO  {2'b00, busy, overrun_any, src_raise & mask}
//     +2 VECTOR   RO  {valid, 5'b0, cur_id}
//     +3 OVERRUN  RO  writing 1 to a bit clears it
//
// Parameters:
//   BASE_ADDR     base of the register window (BASE_ADDR .. BASE_ADDR+3)
//   DROP_TIMEOUT  cycles to wait for the serviced source to drop (1..15)
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   bus_addr       shared IO bus address
//   bus_data       shared IO bus data; driven only in the cycle after a read
//   bus_we         bus write strobe
//   src_raise      level interrupt requests, bit 0 has highest priority
//   src_ack        one-cycle acknowledge pulse to the serviced peripheral
//   cpu_int_raise  merged interrupt request to the processor
//   cpu_int_ack    processor acknowledge of cpu_int_raise
// ---------------------------------------------------------------------------
module interrupt_arbiter #(
    parameter logic [7:0]  BASE_ADDR    = 8'hE0,
    parameter int unsigned DROP_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_addr,
    inout  wire  [7:0] bus_data,
    input  logic       bus_we,
    input  logic [3:0] src_raise,
    output logic [3:0] src_ack,
    output logic       cpu_int_raise,
    input  logic       cpu_int_ack
);

    // Drop counter reload value. The counter is 4 bits wide, so the timeout
    // is taken modulo 16. Values outside 1..15 are not supported.
    localparam logic [3:0] DROP_LOAD = 4'(DROP_TIMEOUT);

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAISE,
        ST_ACK,
        ST_WAIT_DROP
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t     state_reg;
    logic [1:0] cur_id_reg;
    logic       valid_reg;
    logic [3:0] drop_cnt_reg;
    logic       cpu_int_raise_reg;
    logic [3:0] src_ack_reg;
    logic [3:0] mask_reg;
    logic [3:0] ovr_reg;
    logic [7:0] rd_data_reg;
    logic       drive_en_reg;

    // -----------------------------------------------------------------------
    // Bus address decode
    // -----------------------------------------------------------------------
    // The offset is computed with 8-bit wrap-around. This keeps the window
    // correct for any base, even when it is not 4-byte aligned.
    logic [7:0] addr_offset;
    logic       in_window;
    logic [1:0] reg_sel;
    logic       mask_wr;
    logic       ovr_clr_wr;
    logic       bus_rd;

    assign addr_offset = bus_addr - BASE_ADDR;
    assign in_window   = (addr_offset[7:2] == 6'd0);
    assign reg_sel     = addr_offset[1:0];
    assign mask_wr     = bus_we &&  in_window && (reg_sel == REG_MASK);
    assign ovr_clr_wr  = bus_we &&  in_window && (reg_sel == REG_OVERRUN);
    assign bus_rd      = !bus_we && in_window;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [3:0] pending;
    logic [1:0] sel_id;
    logic       any_pending;

    assign pending     = src_raise & mask_reg;
    assign any_pending = |pending;

    // Lowest set index wins. The loop scans downward, so the last match
    // is the lowest index.
    always_comb begin
        sel_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id = 2'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Drop-wait decisions
    // -----------------------------------------------------------------------
    // The counter holds the number of WAIT_DROP cycles still allowed.
    // Decrementing from 1 reaches zero, so that cycle is the timeout.
    logic       cur_still_raised;
    logic       timeout_hit;
    logic [3:0] cur_onehot;
    logic [3:0] ovr_set;

    assign cur_still_raised = src_raise[cur_id_reg];
    assign timeout_hit      = (drop_cnt_reg == 4'd1);
    assign cur_onehot       = 4'b0001 << cur_id_reg;
    assign ovr_set          = (state_reg == ST_WAIT_DROP && cur_still_raised && timeout_hit)
                              ? cur_onehot : 4'b0000;

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    // cpu_int_raise is registered from the RAISE state. It therefore rises
    // one cycle after selection and falls on the edge that accepts the CPU
    // acknowledge. src_ack is loaded on that same edge, so the pulse is high
    // for exactly the one cycle spent in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            cur_id_reg        <= 2'd0;
            valid_reg         <= 1'b0;
            drop_cnt_reg      <= 4'd0;
            cpu_int_raise_reg <= 1'b0;
            src_ack_reg       <= 4'b0000;
        end else begin
            cpu_int_raise_reg <= 1'b0;
            src_ack_reg       <= 4'b0000;
            case (state_reg)
                ST_IDLE: begin
                    if (any_pending) begin
                        cur_id_reg <= sel_id;
                        valid_reg  <= 1'b1;
                        state_reg  <= ST_RAISE;
                    end
                end
                ST_RAISE: begin
                    if (cpu_int_ack) begin
                        src_ack_reg <= cur_onehot;
                        state_reg   <= ST_ACK;
                    end else begin
                        cpu_int_raise_reg <= 1'b1;
                    end
                end
                ST_ACK: begin
                    drop_cnt_reg <= DROP_LOAD;
                    state_reg    <= ST_WAIT_DROP;
                end
                ST_WAIT_DROP: begin
                    // The latched source is always completed. Mask changes
                    // made after selection do not abort the service.
                    if (!cur_still_raised || timeout_hit) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        drop_cnt_reg <= drop_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_int_raise = cpu_int_raise_reg;
    assign src_ack       = src_ack_reg;

    // -----------------------------------------------------------------------
    // MASK register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= 4'hF;
        end else if (mask_wr) begin
            mask_reg <= bus_data[3:0];
        end
    end

    // -----------------------------------------------------------------------
    // OVERRUN register: one sticky bit per source
    // -----------------------------------------------------------------------
    // A timeout on the same edge as a write-1-clear keeps the bit set.
    // Otherwise the overrun event would be lost.
    for (genvar gi = 0; gi < 4; gi++) begin : g_overrun
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovr_reg[gi] <= 1'b0;
            end else if (ovr_set[gi]) begin
                ovr_reg[gi] <= 1'b1;
            end else if (ovr_clr_wr && bus_data[gi]) begin
                ovr_reg[gi] <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [7:0] rd_mux;
    logic       busy;

    assign busy = (state_reg != ST_IDLE);

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            REG_MASK:    rd_mux = {4'h0, mask_reg};
            REG_STATUS:  rd_mux = {2'b00, busy, |ovr_reg, pending};
            REG_VECTOR:  rd_mux = {valid_reg, 5'b00000, cur_id_reg};
            REG_OVERRUN: rd_mux = {4'h0, ovr_reg};
            default:     rd_mux = 8'h00;
        endcase
    end

    // Read data is captured on the address edge. It is driven onto the bus
    // only during the following cycle, and the bus is released after that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= 8'h00;
            drive_en_reg <= 1'b0;
        end else begin
            drive_en_reg <= bus_rd;
            if (bus_rd) begin
                rd_data_reg <= rd_mux;
            end
        end
    end

    assign bus_data = drive_en_reg ? rd_data_reg : 8'hzz;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_interrupt_arbiter
//
// Directed-vector bench for interrupt_arbiter. A service-level model follows
// each arbitration pass and the register file. A compare thread checks
// cpu_int_raise, src_ack and the read data against the model on every
// cycle out of reset. The stimulus sequence also holds hand-computed
// literal expectations.
// ---------------------------------------------------------------------------
module tb_interrupt_arbiter;

    localparam logic [7:0] BASE    = 8'hE0;
    localparam int         TIMEOUT = 15;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [3:0] src_raise;
    logic       cpu_int_ack;
    wire  [3:0] src_ack;
    wire        cpu_int_raise;
    wire  [7:0] bus_data;

    logic       tb_oe;
    logic [7:0] tb_dout;

    assign bus_data = tb_oe ? tb_dout : 8'hzz;

    int checks = 0;
    int errors = 0;

    interrupt_arbiter #(
        .BASE_ADDR    (BASE),
        .DROP_TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_addr      (bus_addr),
        .bus_data      (bus_data),
        .bus_we        (bus_we),
        .src_raise     (src_raise),
        .src_ack       (src_ack),
        .cpu_int_raise (cpu_int_raise),
        .cpu_int_ack   (cpu_int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Service-level model
    //   m_phase: 0 idle, 1 waiting for CPU, 2 acknowledging, 3 waiting drop
    //   m_left:  drop-wait cycles still allowed
    // -----------------------------------------------------------------------
    int         m_phase;
    int         m_cur;
    int         m_left;
    logic [3:0] m_mask;
    logic [3:0] m_ovr;
    logic       m_raise;
    logic [3:0] m_ack;
    logic       m_rd_pending;
    logic [7:0] m_rd_exp;

    always @(posedge clk) begin
        logic [3:0] pend;
        logic [3:0] set_ovr;
        int         off;
        bit         in_win;
        int         old_phase;
        if (!rst_n) begin
            m_phase      = 0;
            m_cur        = 0;
            m_left       = 0;
            m_mask       = 4'hF;
            m_ovr        = 4'h0;
            m_raise      = 1'b0;
            m_ack        = 4'h0;
            m_rd_pending = 1'b0;
            m_rd_exp     = 8'h00;
        end else begin
            pend      = src_raise & m_mask;
            off       = int'(bus_addr) - int'(BASE);
            in_win    = (off >= 0) && (off < 4);
            old_phase = m_phase;
            set_ovr   = 4'h0;

            m_rd_pending = in_win && !bus_we;
            if (m_rd_pending) begin
                case (off)
                    0: m_rd_exp = {4'h0, m_mask};
                    1: m_rd_exp = {2'b00, (old_phase != 0) ? 1'b1 : 1'b0,
                                   (m_ovr != 0) ? 1'b1 : 1'b0, pend};
                    2: m_rd_exp = {(old_phase != 0) ? 1'b1 : 1'b0, 5'b0, 2'(m_cur)};
                    default: m_rd_exp = {4'h0, m_ovr};
                endcase
            end

            m_raise = (old_phase == 1) && !cpu_int_ack;
            m_ack   = ((old_phase == 1) && cpu_int_ack) ? (4'b0001 << m_cur) : 4'b0000;

            case (old_phase)
                0: if (pend != 0) begin
                       for (int i = 3; i >= 0; i--) if (pend[i]) m_cur = i;
                       m_phase = 1;
                   end
                1: if (cpu_int_ack) m_phase = 2;
                2: begin m_phase = 3; m_left = TIMEOUT; end
                default: begin
                    if (!src_raise[m_cur]) m_phase = 0;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            set_ovr[m_cur] = 1'b1;
                            m_phase = 0;
                        end
                    end
                end
            endcase

            if (bus_we && in_win && off == 0) m_mask = tb_dout[3:0];
            if (bus_we && in_win && off == 3) m_ovr = m_ovr & ~tb_dout[3:0];
            m_ovr = m_ovr | set_ovr;
        end
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cyc_raise", {7'b0, cpu_int_raise}, {7'b0, m_raise});
                check("cyc_src_ack", {4'b0, src_ack}, {4'b0, m_ack});
                if (m_rd_pending) check("cyc_rdata", bus_data, m_rd_exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a; bus_we = 1'b1; tb_oe = 1'b1; tb_dout = d;
        step();
        bus_addr = 8'h00; bus_we = 1'b0; tb_oe = 1'b0;
        $display("wr addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus_addr = a; bus_we = 1'b0;
        step();
        bus_addr = 8'h00;
        @(negedge clk);
        d = bus_data;
        $display("rd addr=%h data=%h", a, d);
        step();
    endtask

    // Out-of-window read: the bench drives zero and the DUT must stay off.
    task automatic probe_z(input logic [7:0] a);
        bus_addr = a; bus_we = 1'b0; tb_oe = 1'b1; tb_dout = 8'h00;
        step();
        @(negedge clk);
        check("bus_release", bus_data, 8'h00);
        $display("probe addr=%h data=%h", a, bus_data);
        tb_oe = 1'b0; bus_addr = 8'h00;
        step();
    endtask

    task automatic wait_raise();
        int n = 0;
        while (cpu_int_raise !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("raise_wait", {7'b0, cpu_int_raise}, 8'h01);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    logic [7:0] d;

    initial begin
        rst_n = 1'b0; bus_addr = 8'h00; bus_we = 1'b0; src_raise = 4'h0;
        cpu_int_ack = 1'b0; tb_oe = 1'b0; tb_dout = 8'h00;
        fork compare_loop(); join_none
        steps(3);
        check("rst_raise", {7'b0, cpu_int_raise}, 8'h00);
        check("rst_src_ack", {4'b0, src_ack}, 8'h00);
        rst_n = 1'b1;
        step();

        // Reset register values
        bus_read(BASE + 8'd0, d); check("rst_mask", d, 8'h0F);
        bus_read(BASE + 8'd1, d); check("rst_status", d, 8'h00);
        bus_read(BASE + 8'd2, d); check("rst_vector", d, 8'h00);
        bus_read(BASE + 8'd3, d); check("rst_overrun", d, 8'h00);

        // Two sources pending: index 1 first, then index 2
        src_raise = 4'b0110;
        steps(2);
        check("sel1_raise", {7'b0, cpu_int_raise}, 8'h01);
        bus_read(BASE + 8'd2, d); check("sel1_vector", d, 8'h81);
        cpu_int_ack = 1'b1;
        step();
        check("sel1_src_ack", {4'b0, src_ack}, 8'h02);
        check("sel1_raise_drop", {7'b0, cpu_int_raise}, 8'h00);
        cpu_int_ack = 1'b0; src_raise = 4'b0100;
        step();
        check("sel1_ack_one_cycle", {4'b0, src_ack}, 8'h00);
        steps(3);
        bus_read(BASE + 8'd2, d); check("sel2_vector", d, 8'h82);
        cpu_int_ack = 1'b1;
        step();
        check("sel2_src_ack", {4'b0, src_ack}, 8'h04);
        cpu_int_ack = 1'b0; src_raise = 4'b0000;
        steps(3);

        // Masked-out source never reaches the CPU
        bus_write(BASE, 8'h0E);
        src_raise = 4'b0001;
        steps(4);
        check("masked_raise", {7'b0, cpu_int_raise}, 8'h00);
        bus_read(BASE + 8'd1, d); check("masked_status", d, 8'h00);
        src_raise = 4'b0000;
        bus_write(BASE, 8'h0F);

        // Source 3 never drops: overrun after 15 drop-wait cycles
        src_raise = 4'b1000;
        wait_raise();
        cpu_int_ack = 1'b1;
        step();
        cpu_int_ack = 1'b0;
        bus_write(BASE, 8'h07);
        steps(13);
        bus_read(BASE + 8'd3, d); check("ovr_not_yet", d, 8'h00);
        bus_read(BASE + 8'd3, d); check("ovr_set", d, 8'h08);
        bus_read(BASE + 8'd1, d); check("ovr_status", d, 8'h10);
        bus_write(BASE + 8'd3, 8'h08);
        bus_read(BASE + 8'd3, d); check("ovr_cleared", d, 8'h00);

        // Timeout and write-1-clear on the same edge: the set wins
        bus_write(BASE, 8'h0F);
        wait_raise();
        cpu_int_ack = 1'b1;
        step();
        cpu_int_ack = 1'b0;
        bus_write(BASE, 8'h07);
        steps(14);
        bus_write(BASE + 8'd3, 8'h08);
        bus_read(BASE + 8'd3, d); check("ovr_set_wins", d, 8'h08);
        bus_write(BASE + 8'd3, 8'h08);
        src_raise = 4'b0000;
        bus_write(BASE, 8'h0F);
        steps(2);

        // CPU ack in idle is ignored
        cpu_int_ack = 1'b1;
        step();
        check("idle_ack_src", {4'b0, src_ack}, 8'h00);
        check("idle_ack_raise", {7'b0, cpu_int_raise}, 8'h00);
        cpu_int_ack = 1'b0;
        step();
        bus_read(BASE + 8'd1, d); check("idle_ack_status", d, 8'h00);

        // All four pending: served strictly in index order
        src_raise = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_raise();
            bus_read(BASE + 8'd2, d); check("prio_vector", d, 8'h80 | 8'(k));
            cpu_int_ack = 1'b1;
            step();
            check("prio_src_ack", {4'b0, src_ack}, 8'(4'b0001 << k));
            cpu_int_ack = 1'b0;
            src_raise[k] = 1'b0;
        end
        steps(4);

        // Reset during RAISE abandons the pass
        bus_write(BASE, 8'h05);
        src_raise = 4'b0001;
        steps(2);
        check("pre_rst_raise", {7'b0, cpu_int_raise}, 8'h01);
        rst_n = 1'b0; cpu_int_ack = 1'b1;
        #1;
        check("async_rst_raise", {7'b0, cpu_int_raise}, 8'h00);
        check("async_rst_src_ack", {4'b0, src_ack}, 8'h00);
        steps(2);
        check("in_rst_src_ack", {4'b0, src_ack}, 8'h00);
        cpu_int_ack = 1'b0; src_raise = 4'b0000;
        rst_n = 1'b1;
        step();
        check("post_rst_src_ack", {4'b0, src_ack}, 8'h00);
        bus_read(BASE + 8'd0, d); check("post_rst_mask", d, 8'h0F);

        // Bus released outside the window, right after an in-window read
        bus_read(BASE + 8'd0, d); check("mask_again", d, 8'h0F);
        probe_z(BASE + 8'd4);
        probe_z(BASE - 8'd1);
        probe_z(8'h10);

        steps(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
